spi_master: RTL
===============

# spi_master

Clocked SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first) that drives the serial pins of the FFT SPI minion. It lets one chip-side block, or a second Caravel design on a test board, push parallel words into the minion and collect its replies. A val/rdy request port supplies one NBITS-wide word per transaction, and a val/rdy response port returns the NBITS bits shifted in on miso. All logic runs on the single system clock; sclk is a divided, registered output.

## Interface
- NBITS, 34: bits per transaction (cs-low frame length); must be ≥1.
- CLK_DIV, 4: clk cycles per sclk half-period; must be ≥1, and ≥4 when driving the minion (its input synchronizers).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- recv_val  input  1  request word valid.
- recv_rdy  output  1  block can accept a request word.
- recv_msg  input  NBITS  word to shift out on mosi.
- send_val  output  1  response word valid.
- send_rdy  input  1  consumer accepts response.
- send_msg  output  NBITS  word shifted in from miso.
- cs  output  1  chip select, active low.
- sclk  output  1  serial clock, idle low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

## Operation
- States: GAP, IDLE, SETUP, HIGH, LOW, DONE.
- Reset (async) forces: state GAP, div counter 0, bit counter 0, cs=1, sclk=0, mosi=0, recv_rdy=0, send_val=0, send_msg=0, tx/rx shift registers 0.
- GAP: cs=1. Stays CLK_DIV cycles, then goes to IDLE.
- IDLE: recv_rdy=1. On recv_val&&recv_rdy, load the tx shift register with recv_msg and go to SETUP.
- SETUP: cs=0, sclk=0, mosi=tx[NBITS-1]. Lasts CLK_DIV cycles, then goes to HIGH.
- HIGH: sclk=1, lasts CLK_DIV cycles. In the last cycle, shift miso into rx LSB (rx shifts left). Then go to LOW.
- LOW: sclk=0. The first LOW cycle drives mosi with the next tx bit (tx shifts left, 0 fills). Lasts CLK_DIV cycles.
  - If the bit counter is below NBITS-1: increment it and go to HIGH.
  - Otherwise: go to DONE.
- DONE: cs=1, sclk=0, mosi=0, send_val=1, send_msg=rx.
  - On send_rdy, go to GAP.
  - While send_rdy=0, hold DONE indefinitely with cs high.
- recv_rdy is high only in IDLE. A request is never accepted mid-frame or while a response is pending.
- miso is sampled directly, with no synchronizer. Sampling at the end of the high phase gives the minion CLK_DIV cycles after the rising edge.
- Reset mid-frame aborts immediately: cs rises, and the partial rx word is discarded (send_val stays 0).

## Timing
- Request handshake at cycle t. Then:
  - cs falls at t+1.
  - First sclk rise at t+1+CLK_DIV.
  - Bit i is high during cycles t+1+CLK_DIV(1+2i) … t+CLK_DIV(2+2i).
  - cs rises, with send_val=1, at t+1+CLK_DIV(1+2·NBITS).
- With send_rdy=1 in the DONE cycle, the next request is accepted no earlier than CLK_DIV+1 cycles after cs rises. Minimum cs-high time is CLK_DIV+1 cycles.
- All pin outputs are registered. There is no combinational path from any input to any output except send_rdy into the next-state logic.
- After reset deassertion, recv_rdy rises after CLK_DIV cycles.

## Structure
- Package spi_master_pkg holds:
  - the state enum typedef (GAP, IDLE, SETUP, HIGH, LOW, DONE);
  - the mode constants CPOL=0, CPHA=0.
- Counter widths are $clog2(CLK_DIV+1) for the divider and $clog2(NBITS+1) for the bit counter.
- One sub-module, spi_master_shreg: NBITS-wide, with parallel load, left shift, serial in and serial out. It is instantiated twice (tx, rx); the FSM stays in spi_master.

## Test plan
- NBITS=8, CLK_DIV=2, recv_msg=0xA5, miso looped to mosi:
  - cs falls at cycle 1 and rises at cycle 35;
  - mosi pattern 1010_0101 at each sclk rise;
  - send_msg=0xA5, send_val at cycle 35.
- miso tied to 1, recv_msg=0x00 → mosi 0 for all bits; send_msg=0xFF.
- send_rdy held 0 for 10 cycles after DONE:
  - cs stays 1, send_val held, recv_rdy=0;
  - after send_rdy, recv_rdy rises CLK_DIV+1 cycles later.
- Back-to-back requests with recv_val held 1 → exactly one word accepted per frame; cs-high gap ≥ CLK_DIV+1 cycles.
- Assert reset at bit 3 of a frame:
  - same cycle: cs=1, sclk=0, mosi=0, send_val=0;
  - after release, recv_rdy rises after CLK_DIV cycles and the next frame is clean.
- NBITS=34, CLK_DIV=4, against the minion model → 34 rising edges per frame; response matches the minion's transmitted word.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and mode constants for the SPI initiator.
package spi_master_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        GAP   = 3'd0,   // enforced cs-high time between frames
        IDLE  = 3'd1,   // waiting for a request word
        SETUP = 3'd2,   // cs low, first data bit presented, sclk still low
        HIGH  = 3'd3,   // sclk high phase of one bit
        LOW   = 3'd4,   // sclk low phase of one bit
        DONE  = 3'd5    // response word offered, cs high
    } state_e;

    // SPI mode 0: sclk idles low, data captured on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // With CPHA=0 the remote side launches on the falling edge, so the
    // latest safe capture point is the end of the high phase.
    localparam state_e SAMPLE_STATE = (CPHA == 1'b0) ? HIGH : LOW;

endpackage

// File: rtl/spi_master_shreg.sv
// Left-shifting register with parallel load, serial in at the LSB and
// serial out from the MSB. Used for both the transmit and receive paths.
module spi_master_shreg #(
    parameter int NBITS = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic             shift,
    input  logic             sin,
    output logic [NBITS-1:0] q,
    output logic             sout
);

    logic [NBITS-1:0] shifted;

    // Written as a shift-and-or so a one-bit register still elaborates.
    assign shifted = (q << 1) | NBITS'(sin);

    // Serial out is always the current MSB.
    assign sout = q[NBITS-1];

    // Load wins over shift; both are single-cycle strobes from the sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator. One request word in, one frame of NBITS bits on the
// pins, one response word out. sclk is derived from clk by counting CLK_DIV
// cycles per half period; every pin is driven straight from a flop.
//
// Handshakes: a word moves on recv_* or send_* in a cycle where both val and
// rdy are high at the rising clk edge; val, once raised, is not dropped by
// this block until that transfer happens, and rdy never depends
// combinationally on val in the same cycle.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int NBITS   = 34,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recv_val,
    output logic             recv_rdy,
    input  logic [NBITS-1:0] recv_msg,
    output logic             send_val,
    input  logic             send_rdy,
    output logic [NBITS-1:0] send_msg,
    output logic             cs,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output state_e           dbg_state
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    state_e           state;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             div_done;
    logic             accept;
    logic             bit_shift;
    logic [NBITS-1:0] rx_q;
    logic [NBITS-1:0] tx_q_unused;
    logic             rx_msb_unused;

    assign dbg_state = state;

    // Last cycle of the current timed phase (GAP, SETUP, HIGH, LOW).
    assign div_done = (div_cnt == DIV_LAST);

    // recv_rdy is only ever high in IDLE, so this is the request transfer.
    assign accept = recv_val && recv_rdy;

    // One strobe per bit at the end of the high phase: the receive side
    // captures miso and the transmit side advances so the next bit appears
    // on mosi together with the falling sclk edge.
    assign bit_shift = (state == SAMPLE_STATE) && div_done;

    // Transmit path: mosi is the MSB flop itself. Zeros are shifted in, so
    // after a full frame (or a reset) mosi rests at 0 without extra gating.
    spi_master_shreg #(.NBITS(NBITS)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (recv_msg),
        .shift    (bit_shift),
        .sin      (1'b0),
        .q        (tx_q_unused),
        .sout     (mosi)
    );

    // Receive path: cleared at the start of every frame, miso enters at LSB.
    spi_master_shreg #(.NBITS(NBITS)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val ('0),
        .shift    (bit_shift),
        .sin      (miso),
        .q        (rx_q),
        .sout     (rx_msb_unused)
    );

    // Frame sequencer with registered pin and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= GAP;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            cs       <= 1'b1;
            sclk     <= CPOL;
            recv_rdy <= 1'b0;
            send_val <= 1'b0;
            send_msg <= '0;
        end else begin
            case (state)
                GAP: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        state    <= IDLE;
                        recv_rdy <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (accept) begin
                        state    <= SETUP;
                        recv_rdy <= 1'b0;
                        cs       <= 1'b0;
                        sclk     <= CPOL;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end

                SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= HIGH;
                        sclk    <= ~CPOL;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                HIGH: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= LOW;
                        sclk    <= CPOL;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                LOW: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (bit_cnt < BIT_LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= HIGH;
                            sclk    <= ~CPOL;
                        end else begin
                            // rx already holds the final bit from the last
                            // high phase, so it can be published now.
                            state    <= DONE;
                            cs       <= 1'b1;
                            send_val <= 1'b1;
                            send_msg <= rx_q;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // cs stays high for as long as the consumer stalls.
                    if (send_rdy) begin
                        send_val <= 1'b0;
                        div_cnt  <= '0;
                        state    <= GAP;
                    end
                end

                default: begin
                    state    <= GAP;
                    div_cnt  <= '0;
                    cs       <= 1'b1;
                    sclk     <= CPOL;
                    recv_rdy <= 1'b0;
                    send_val <= 1'b0;
                end
            endcase
        end
    end

endmodule
